wb_commit_stage: RTL and testbench
==================================

// Module: wb_commit_stage
// PURPOSE
//  Write-back/commit stage directly downstream of the load/store unit. Accepts one retired
//  instruction per valid/ready handshake, selects load data or ALU result, writes the register
//  file, and hands the next PC back to instruction fetch. A bus error reported with the
//  instruction suppresses the write and raises a sticky trap; the core halts until reset.
// PARAMETERS
//  XLEN          32   datapath / PC width
//  INSTRET_W     64   width of retired-instruction counter
//  CAUSE_LD_ERR  5    trap_cause code for load access fault
//  CAUSE_ST_ERR  7    trap_cause code for store access fault
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous reset, active-high
//  in_valid      in   1     upstream (LSU) has a finished instruction
//  in_ready      out  1     this stage can accept
//  pc            in   XLEN  PC of incoming instruction
//  next_pc       in   XLEN  computed next PC (branch/jump resolved)
//  alu_result    in   XLEN  EXU result
//  load_data     in   XLEN  extended load data from LSU
//  is_load       in   1     instruction is a load (select load_data)
//  is_store      in   1     instruction is a store
//  rd            in   5     destination register index
//  rd_wen        in   1     instruction writes rd
//  resp_err      in   1     bus response error for this instruction
//  rf_wen        out  1     register-file write strobe
//  rf_waddr      out  5     register-file write index
//  rf_wdata      out  XLEN  register-file write data
//  out_valid     out  1     next PC valid to fetch
//  out_ready     in   1     fetch accepts next PC
//  out_pc        out  XLEN  next PC handed to fetch
//  trap_valid    out  1     sticky trap indicator
//  trap_pc       out  XLEN  PC of faulting instruction
//  trap_cause    out  4     CAUSE_LD_ERR or CAUSE_ST_ERR
//  instret       out  INSTRET_W  count of committed (non-trapped) instructions
// BEHAVIOUR
//  - States: IDLE, COMMIT, TRAP. Reset -> IDLE; all latches 0, instret 0, trap_* 0.
//  - in_ready = (IDLE) | (COMMIT & out_ready & !err_q). in_fire = in_valid & in_ready.
//  - On in_fire: latch pc, next_pc, wdata = is_load ? load_data : alu_result, rd,
//    wen_q = rd_wen & (rd!=0), ld_q = is_load, st_q = is_store, err_q = resp_err; state -> COMMIT.
//  - COMMIT, err_q=0: out_valid=1, out_pc=next_pc_q. out_fire = out_valid & out_ready.
//    On out_fire: rf_wen=wen_q (same cycle, combinational), instret+=1; state -> COMMIT
//    if in_fire same cycle (back-to-back, new entry latched), else IDLE.
//  - COMMIT, err_q=1: out_valid=0, rf_wen=0; next cycle state -> TRAP, trap_valid=1,
//    trap_pc=pc_q, trap_cause = ld_q ? CAUSE_LD_ERR : CAUSE_ST_ERR. instret unchanged.
//  - TRAP: absorbing until rst; in_ready=0, out_valid=0, rf_wen=0, trap_* held.
//  - rf_waddr/rf_wdata always driven from latches; meaningful only when rf_wen=1.
//  - rf_wen never asserted for rd=0, even if rd_wen=1.
//  - out_valid, once raised, stays high with stable out_pc until out_fire (no retraction).
//  - Back-to-back throughput: 1 instruction/cycle when in_valid and out_ready held high.
//  - instret wraps modulo 2^INSTRET_W.
//  - rst in any state (incl. mid-COMMIT with out_valid high): next cycle IDLE, no write,
//    pending instruction dropped, trap cleared.
// TESTING
//  - Single ALU op: pc=0x80000000,next_pc=0x80000004,alu=0x1234,rd=5,rd_wen=1,out_ready=1
//    -> 1 cycle later rf_wen=1,waddr=5,wdata=0x1234,out_pc=0x80000004,instret=1.
//  - Load select: is_load=1,load_data=0xFFFFFF80,alu=0x10,rd=3 -> wdata=0xFFFFFF80.
//  - rd=0 with rd_wen=1 -> out_fire occurs, rf_wen stays 0, instret increments.
//  - Backpressure: out_ready=0 for 4 cycles -> out_valid/out_pc stable, in_ready=0, no rf_wen;
//    out_ready=1 -> exactly one rf_wen pulse.
//  - Streaming 8 instrs, in_valid/out_ready high -> 8 rf_wen in 8 consecutive cycles, instret=8.
//  - Load error pc=0x80000100: resp_err=1,is_load=1 -> no rf_wen/out_valid, trap_valid=1,
//    trap_pc=0x80000100,cause=5, in_ready=0 until rst; store error -> cause=7.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: one-entry buffer between the LSU and fetch. It drives the
// register-file write and the next PC, and latches a sticky trap when a bus error arrives.
module wb_commit_stage #(
  parameter int         XLEN         = 32,
  parameter int         INSTRET_W    = 64,
  parameter logic [3:0] CAUSE_LD_ERR = 4'd5,
  parameter logic [3:0] CAUSE_ST_ERR = 4'd7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      next_pc,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      load_data,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [4:0]           rd,
  input  logic                 rd_wen,
  input  logic                 resp_err,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic                 trap_valid,
  output logic [XLEN-1:0]      trap_pc,
  output logic [3:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [1:0] {IDLE, COMMIT, TRAP} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, next_pc_q, wdata_q;
  logic [4:0]      rd_q;
  logic            wen_q, ld_q, st_q, err_q;
  logic            in_fire, out_fire, trap_enter;
  logic [3:0]      cause_sel;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    trap_enter = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = COMMIT;
      end
      COMMIT: begin
        if (err_q) begin
          trap_enter = 1'b1;
          state_next = TRAP;
        end else begin
          out_valid = 1'b1;
          // Accept the next instruction in the same cycle the current one retires.
          in_ready  = out_ready;
          if (out_ready) state_next = in_valid ? COMMIT : IDLE;
        end
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign rf_wen   = out_fire & wen_q;
  assign rf_waddr = rd_q;
  assign rf_wdata = wdata_q;
  assign out_pc   = next_pc_q;

  // A load fault wins if the upstream ever flags both kinds at once.
  always_comb begin
    case ({ld_q, st_q})
      2'b10, 2'b11: cause_sel = CAUSE_LD_ERR;
      default:      cause_sel = CAUSE_ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      next_pc_q  <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      err_q      <= 1'b0;
      trap_valid <= 1'b0;
      trap_pc    <= '0;
      trap_cause <= '0;
      instret    <= '0;
    end else begin
      state <= state_next;
      if (in_fire) begin
        pc_q      <= pc;
        next_pc_q <= next_pc;
        wdata_q   <= is_load ? load_data : alu_result;
        rd_q      <= rd;
        wen_q     <= rd_wen & (rd != 5'd0);
        ld_q      <= is_load;
        st_q      <= is_store;
        err_q     <= resp_err;
      end
      if (out_fire) instret <= instret + INSTRET_W'(1);
      if (trap_enter) begin
        trap_valid <= 1'b1;
        trap_pc    <= pc_q;
        trap_cause <= cause_sel;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a one-slot transaction model.
module tb_wb_commit_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] pc = '0, next_pc = '0, alu_result = '0, load_data = '0;
  logic        is_load = 1'b0, is_store = 1'b0, rd_wen = 1'b0, resp_err = 1'b0;
  logic [4:0]  rd = '0;
  logic        rf_wen, out_valid, trap_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, out_pc, trap_pc;
  logic [3:0]  trap_cause;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  wb_commit_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .next_pc(next_pc), .alu_result(alu_result), .load_data(load_data),
    .is_load(is_load), .is_store(is_store), .rd(rd), .rd_wen(rd_wen), .resp_err(resp_err),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] np, input logic [31:0] alu,
                      input logic [31:0] ld, input logic isl, input logic iss,
                      input logic [4:0] r, input logic we, input logic err);
    in_valid = 1'b1; pc = p; next_pc = np; alu_result = alu; load_data = ld;
    is_load = isl; is_store = iss; rd = r; rd_wen = we; resp_err = err;
  endtask

  // Transaction model: at most one instruction held, plus a sticky trap record.
  logic        m_ok = 1'b0, m_pend = 1'b0, m_trap = 1'b0;
  logic [31:0] m_npc, m_wdata, m_pc, m_tpc;
  logic [4:0]  m_rd;
  logic        m_wen, m_err, m_ld;
  logic [3:0]  m_tcause;
  logic [63:0] m_cnt;

  always begin
    logic e_in_ready, e_out_valid, e_rf_wen, in_fire, out_fire;
    @(negedge clk);
    e_in_ready  = !m_trap && (!m_pend || (!m_err && out_ready));
    e_out_valid = m_pend && !m_err;
    e_rf_wen    = e_out_valid && out_ready && m_wen;
    if (m_ok) begin
      chk("in_ready", in_ready, e_in_ready);
      chk("out_valid", out_valid, e_out_valid);
      chk("rf_wen", rf_wen, e_rf_wen);
      chk("instret", instret, m_cnt);
      chk("trap_valid", trap_valid, m_trap);
      if (e_out_valid) chk("out_pc", out_pc, m_npc);
      if (e_rf_wen) begin
        chk("rf_waddr", rf_waddr, m_rd);
        chk("rf_wdata", rf_wdata, m_wdata);
      end
      if (m_trap) begin
        chk("trap_pc", trap_pc, m_tpc);
        chk("trap_cause", trap_cause, m_tcause);
      end
    end
    in_fire  = in_valid && e_in_ready;
    out_fire = e_out_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      m_ok = 1'b1; m_pend = 1'b0; m_trap = 1'b0; m_cnt = '0;
    end else if (m_ok) begin
      if (out_fire) m_cnt = m_cnt + 1;
      if (m_pend && m_err) begin
        m_trap = 1'b1; m_tpc = m_pc; m_tcause = m_ld ? 4'd5 : 4'd7; m_pend = 1'b0;
      end else if (out_fire) begin
        m_pend = 1'b0;
      end
      if (in_fire) begin
        m_pend = 1'b1; m_pc = pc; m_npc = next_pc; m_rd = rd; m_ld = is_load;
        m_wdata = is_load ? load_data : alu_result;
        m_wen = rd_wen && (rd != 5'd0);
        m_err = resp_err;
      end
    end
  end

  initial begin
    int wen_cnt;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    chk("reset instret", instret, 64'd0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset trap_valid", trap_valid, 1'b0);

    // Single ALU op
    out_ready = 1'b1;
    send(32'h8000_0000, 32'h8000_0004, 32'h1234, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    cycle(); in_valid = 1'b0; #1;
    chk("alu rf_wen", rf_wen, 1'b1);
    chk("alu waddr", rf_waddr, 5'd5);
    chk("alu wdata", rf_wdata, 32'h1234);
    chk("alu out_pc", out_pc, 32'h8000_0004);
    cycle();
    chk("alu instret", instret, 64'd1);
    $display("txn alu: instret=%0d", instret);

    // Load select
    send(32'h8000_0004, 32'h8000_0008, 32'h10, 32'hFFFF_FF80, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    cycle(); in_valid = 1'b0; #1;
    chk("load rf_wen", rf_wen, 1'b1);
    chk("load waddr", rf_waddr, 5'd3);
    chk("load wdata", rf_wdata, 32'hFFFF_FF80);
    cycle();
    chk("load instret", instret, 64'd2);
    $display("txn load: wdata=%h", rf_wdata);

    // rd = 0 never writes but still retires
    send(32'h8000_0008, 32'h8000_000C, 32'h55, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cycle(); in_valid = 1'b0; #1;
    chk("rd0 out_valid", out_valid, 1'b1);
    chk("rd0 rf_wen", rf_wen, 1'b0);
    cycle();
    chk("rd0 instret", instret, 64'd3);
    $display("txn rd0: instret=%0d", instret);

    // Backpressure
    out_ready = 1'b0;
    send(32'h100, 32'h200, 32'hAA, 32'h0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp out_pc", out_pc, 32'h200);
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp rf_wen", rf_wen, 1'b0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("bp release rf_wen", rf_wen, 1'b1);
    cycle();
    chk("bp single pulse", rf_wen, 1'b0);
    $display("txn backpressure: instret=%0d", instret);

    // Streaming 8 back-to-back
    rst = 1'b1; cycle(); rst = 1'b0;
    wen_cnt = 0;
    send(32'h1000, 32'h1004, 32'd100, 32'h0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
    cycle();
    for (int i = 1; i <= 8; i++) begin
      if (i < 8)
        send(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 32'(100 + i), 32'h0,
             1'b0, 1'b0, 5'(i + 1), 1'b1, 1'b0);
      else
        in_valid = 1'b0;
      #1;
      if (rf_wen) wen_cnt++;
      cycle();
    end
    chk("stream wen count", 64'(wen_cnt), 64'd8);
    chk("stream instret", instret, 64'd8);
    $display("txn stream: wen=%0d instret=%0d", wen_cnt, instret);

    // Load access fault
    send(32'h8000_0100, 32'h8000_0104, 32'h1, 32'h2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    cycle(); in_valid = 1'b0; #1;
    chk("lderr out_valid", out_valid, 1'b0);
    chk("lderr rf_wen", rf_wen, 1'b0);
    chk("lderr in_ready", in_ready, 1'b0);
    cycle();
    chk("lderr trap_valid", trap_valid, 1'b1);
    chk("lderr trap_pc", trap_pc, 32'h8000_0100);
    chk("lderr cause", trap_cause, 4'd5);
    send(32'h4, 32'h8, 32'h3, 32'h0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("trap in_ready", in_ready, 1'b0);
      chk("trap instret", instret, 64'd8);
    end
    in_valid = 1'b0;
    $display("txn load err: cause=%0d", trap_cause);

    // Store access fault after reset
    rst = 1'b1; cycle(); rst = 1'b0; #1;
    chk("rst clears trap", trap_valid, 1'b0);
    send(32'h8000_0200, 32'h8000_0204, 32'h1, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
    cycle(); in_valid = 1'b0; cycle();
    chk("sterr cause", trap_cause, 4'd7);
    chk("sterr trap_pc", trap_pc, 32'h8000_0200);
    $display("txn store err: cause=%0d", trap_cause);

    // Reset while holding an instruction with out_valid high
    rst = 1'b1; cycle(); rst = 1'b0;
    out_ready = 1'b0;
    send(32'h300, 32'h304, 32'h9, 32'h0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    cycle(); in_valid = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0; out_ready = 1'b1; #1;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst rf_wen", rf_wen, 1'b0);
    chk("midrst instret", instret, 64'd0);
    $display("txn mid-commit reset: out_valid=%0b", out_valid);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      pc         = $urandom; next_pc = $urandom;
      alu_result = $urandom; load_data = $urandom;
      is_load    = $urandom_range(0, 1) == 1;
      is_store   = !is_load && ($urandom_range(0, 1) == 1);
      rd         = 5'($urandom_range(0, 31));
      rd_wen     = ($urandom_range(0, 3) != 0);
      resp_err   = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    cycle(); cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
